// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU share arbiter.
// Opcode constants follow the ALU's own encoding so both sides agree.
package alu_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [5:0] OPRN_ADD = 6'h01;
  localparam logic [5:0] OPRN_SUB = 6'h02;
  localparam logic [5:0] OPRN_MUL = 6'h03;
  localparam logic [5:0] OPRN_SHR = 6'h04;
  localparam logic [5:0] OPRN_SHL = 6'h05;
  localparam logic [5:0] OPRN_AND = 6'h06;
  localparam logic [5:0] OPRN_OR  = 6'h07;
  localparam logic [5:0] OPRN_NOR = 6'h08;
  localparam logic [5:0] OPRN_SLT = 6'h09;

  localparam logic [3:0] OPRN_MAX = 4'h9;

  // Only the low nibble is decoded; the upper opcode bits pass through untouched.
  function automatic logic oprn_illegal(input logic [3:0] code);
    return (code == 4'h0) || (code > OPRN_MAX);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the
// requester that was not served last. Purely combinational.
module rr_arb2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  assign gnt_o[0] = valid0_i && (!valid1_i || last_i);
  assign gnt_o[1] = valid1_i && (!valid0_i || !last_i);

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters: accept, execute
// from registered operands, then hold the result until the owner takes it.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OPRN_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic [DATA_W-1:0] REQ0_OP1,
  input  logic [DATA_W-1:0] REQ0_OP2,
  input  logic [OPRN_W-1:0] REQ0_OPRN,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic [DATA_W-1:0] REQ1_OP1,
  input  logic [DATA_W-1:0] REQ1_OP2,
  input  logic [OPRN_W-1:0] REQ1_OPRN,
  output logic              RSP0_VALID,
  input  logic              RSP0_READY,
  output logic              RSP1_VALID,
  input  logic              RSP1_READY,
  output logic [DATA_W-1:0] RSP_OUT,
  output logic              RSP_ZERO,
  output logic              RSP_ERR,
  output logic [DATA_W-1:0] ALU_OP1,
  output logic [DATA_W-1:0] ALU_OP2,
  output logic [OPRN_W-1:0] ALU_OPRN,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic              ALU_ZERO
);

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [OPRN_W-1:0]   oprn_q, oprn_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                zf_q, zf_d;
  logic                err_q, err_d;
  logic [1:0]          gnt;
  logic                idle;
  logic                rsp_rdy;

  rr_arb2 u_rr_arb2 (
    .valid0_i (REQ0_VALID),
    .valid1_i (REQ1_VALID),
    .last_i   (last_q),
    .gnt_o    (gnt)
  );

  // Reset masks the handshakes so nothing is accepted or delivered while it is held.
  assign idle       = (state_q == ST_IDLE) && !RST;
  assign REQ0_READY = idle && gnt[0];
  assign REQ1_READY = idle && gnt[1];
  assign RSP0_VALID = (state_q == ST_RESP) && !RST && !owner_q;
  assign RSP1_VALID = (state_q == ST_RESP) && !RST && owner_q;
  assign rsp_rdy    = owner_q ? RSP1_READY : RSP0_READY;

  assign RSP_OUT  = res_q;
  assign RSP_ZERO = zf_q;
  assign RSP_ERR  = err_q;
  assign ALU_OP1  = op1_q;
  assign ALU_OP2  = op2_q;
  assign ALU_OPRN = oprn_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    oprn_d  = oprn_q;
    res_d   = res_q;
    zf_d    = zf_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt[0] || gnt[1]) begin
          owner_d = gnt[1];
          last_d  = gnt[1];
          op1_d   = gnt[1] ? REQ1_OP1  : REQ0_OP1;
          op2_d   = gnt[1] ? REQ1_OP2  : REQ0_OP2;
          oprn_d  = gnt[1] ? REQ1_OPRN : REQ0_OPRN;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = ALU_OUT;
        zf_d    = ALU_ZERO;
        err_d   = oprn_illegal(oprn_q[3:0]);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      oprn_q  <= '0;
      res_q   <= '0;
      zf_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      oprn_q  <= oprn_d;
      res_q   <= res_d;
      zf_q    <= zf_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
  logic [31:0] REQ0_OP1, REQ0_OP2, REQ1_OP1, REQ1_OP2;
  logic [5:0]  REQ0_OPRN, REQ1_OPRN;
  logic        RSP0_VALID, RSP0_READY, RSP1_VALID, RSP1_READY;
  logic [31:0] RSP_OUT;
  logic        RSP_ZERO, RSP_ERR;
  logic [31:0] ALU_OP1, ALU_OP2, ALU_OUT;
  logic [5:0]  ALU_OPRN;
  logic        ALU_ZERO;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alu_share_arbiter dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
    .REQ0_OP1(REQ0_OP1), .REQ0_OP2(REQ0_OP2), .REQ0_OPRN(REQ0_OPRN),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
    .REQ1_OP1(REQ1_OP1), .REQ1_OP2(REQ1_OP2), .REQ1_OPRN(REQ1_OPRN),
    .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY),
    .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY),
    .RSP_OUT(RSP_OUT), .RSP_ZERO(RSP_ZERO), .RSP_ERR(RSP_ERR),
    .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
    .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO)
  );

  // Behavioural ALU; unknown opcodes produce zero.
  always_comb begin
    case (ALU_OPRN)
      OPRN_ADD: ALU_OUT = ALU_OP1 + ALU_OP2;
      OPRN_SUB: ALU_OUT = ALU_OP1 - ALU_OP2;
      OPRN_MUL: ALU_OUT = ALU_OP1 * ALU_OP2;
      OPRN_SHR: ALU_OUT = ALU_OP1 >> ALU_OP2;
      OPRN_SHL: ALU_OUT = ALU_OP1 << ALU_OP2;
      OPRN_AND: ALU_OUT = ALU_OP1 & ALU_OP2;
      OPRN_OR:  ALU_OUT = ALU_OP1 | ALU_OP2;
      OPRN_NOR: ALU_OUT = ~(ALU_OP1 | ALU_OP2);
      OPRN_SLT: ALU_OUT = {31'd0, $signed(ALU_OP1) < $signed(ALU_OP2)};
      default:  ALU_OUT = 32'd0;
    endcase
    ALU_ZERO = (ALU_OUT == 32'd0);
  end

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    REQ0_VALID = 0; REQ1_VALID = 0; RSP0_READY = 0; RSP1_READY = 0;
    REQ0_OP1 = 0; REQ0_OP2 = 0; REQ0_OPRN = 0;
    REQ1_OP1 = 0; REQ1_OP2 = 0; REQ1_OPRN = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    RST = 1;
    tick();
    RST = 0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    REQ0_VALID = 1;
    REQ1_VALID = 1;
    tick();
    checks++;
    if ({REQ0_READY, REQ1_READY} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", {REQ0_READY, REQ1_READY});
    end
    RST = 0;
    REQ0_VALID = 0;
    REQ1_VALID = 0;
    #1;
    checks++;
    if ({RSP0_VALID, RSP1_VALID, RSP_ZERO, RSP_ERR} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {RSP0_VALID, RSP1_VALID, RSP_ZERO, RSP_ERR});
    end
    checks++;
    if ({ALU_OP1, ALU_OP2, ALU_OPRN, RSP_OUT} !== 102'd0) begin
      errors++; $display("FAIL reset_data: op1=%h op2=%h oprn=%h out=%h expected all 0", ALU_OP1, ALU_OP2, ALU_OPRN, RSP_OUT);
    end
  endtask

  task automatic test_single_op();
    REQ0_VALID = 1; REQ0_OP1 = 32'h5; REQ0_OP2 = 32'h3; REQ0_OPRN = 6'h01; RSP0_READY = 1;
    #1;
    checks++;
    if ({REQ0_READY, REQ1_READY} !== 2'b10) begin
      errors++; $display("FAIL single_ready: got %b expected 10", {REQ0_READY, REQ1_READY});
    end
    tick();
    REQ0_VALID = 0;
    #1;
    checks++;
    if (RSP0_VALID !== 1'b0 || ALU_OP1 !== 32'h5 || ALU_OP2 !== 32'h3 || ALU_OPRN !== 6'h01) begin
      errors++; $display("FAIL single_exec: vld=%b op1=%h op2=%h oprn=%h expected 0/5/3/01", RSP0_VALID, ALU_OP1, ALU_OP2, ALU_OPRN);
    end
    tick();
    checks++;
    if (RSP0_VALID !== 1'b1 || RSP1_VALID !== 1'b0 || RSP_OUT !== 32'h8 || RSP_ZERO !== 1'b0 || RSP_ERR !== 1'b0) begin
      errors++; $display("FAIL single_rsp: vld0=%b vld1=%b out=%h z=%b e=%b expected 1/0/8/0/0", RSP0_VALID, RSP1_VALID, RSP_OUT, RSP_ZERO, RSP_ERR);
    end
    tick();
    checks++;
    if (RSP0_VALID !== 1'b0) begin
      errors++; $display("FAIL single_done: vld0=%b expected 0", RSP0_VALID);
    end
    RSP0_READY = 0;
  endtask

  task automatic test_back_to_back();
    logic exp_g;
    apply_reset();
    REQ0_VALID = 1; REQ0_OP1 = 32'd7; REQ0_OP2 = 32'd7; REQ0_OPRN = OPRN_SUB;
    REQ1_VALID = 1; REQ1_OP1 = 32'd2; REQ1_OP2 = 32'd9; REQ1_OPRN = OPRN_SLT;
    RSP0_READY = 1; RSP1_READY = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_g = i[0];
      checks++;
      if ({REQ1_READY, REQ0_READY} !== (exp_g ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL tie_grant[%0d]: ready1,0=%b expected winner %0d", i, {REQ1_READY, REQ0_READY}, exp_g);
      end
      tick();
      checks++;
      if ({REQ1_READY, REQ0_READY, RSP1_VALID, RSP0_VALID} !== 4'b0000) begin
        errors++; $display("FAIL tie_exec[%0d]: rdy/vld=%b expected 0000", i, {REQ1_READY, REQ0_READY, RSP1_VALID, RSP0_VALID});
      end
      tick();
      checks++;
      if ({RSP1_VALID, RSP0_VALID} !== (exp_g ? 2'b10 : 2'b01) ||
          RSP_OUT !== (exp_g ? 32'h1 : 32'h0) || RSP_ZERO !== !exp_g || RSP_ERR !== 1'b0) begin
        errors++; $display("FAIL tie_rsp[%0d]: vld1,0=%b out=%h z=%b e=%b expected owner %0d", i, {RSP1_VALID, RSP0_VALID}, RSP_OUT, RSP_ZERO, RSP_ERR, exp_g);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    REQ1_VALID = 1; REQ1_OP1 = 32'h0000F0F0; REQ1_OP2 = 32'h0000FF00; REQ1_OPRN = OPRN_AND;
    RSP1_READY = 0;
    #1;
    checks++;
    if ({REQ1_READY, REQ0_READY} !== 2'b10) begin
      errors++; $display("FAIL bp_grant: ready1,0=%b expected 10", {REQ1_READY, REQ0_READY});
    end
    tick();
    REQ1_VALID = 0;
    REQ0_VALID = 1; REQ0_OP1 = 32'd1; REQ0_OP2 = 32'd1; REQ0_OPRN = OPRN_ADD;
    RSP0_READY = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (RSP1_VALID !== 1'b1 || RSP0_VALID !== 1'b0 || RSP_OUT !== 32'h0000F000 ||
          RSP_ZERO !== 1'b0 || {REQ1_READY, REQ0_READY} !== 2'b00) begin
        errors++; $display("FAIL bp_hold[%0d]: vld1=%b vld0=%b out=%h z=%b rdy=%b expected 1/0/0000f000/0/00", i, RSP1_VALID, RSP0_VALID, RSP_OUT, RSP_ZERO, {REQ1_READY, REQ0_READY});
      end
      tick();
    end
    RSP1_READY = 1;
    tick();
    checks++;
    if (RSP1_VALID !== 1'b0 || REQ0_READY !== 1'b1) begin
      errors++; $display("FAIL bp_release: vld1=%b ready0=%b expected 0/1", RSP1_VALID, REQ0_READY);
    end
    idle_inputs();
    #1;
  endtask

  task automatic test_illegal();
    REQ0_VALID = 1; REQ0_OP1 = 32'd123; REQ0_OP2 = 32'd456; REQ0_OPRN = 6'h0C; RSP0_READY = 1;
    tick();
    REQ0_VALID = 0;
    tick();
    checks++;
    if (RSP0_VALID !== 1'b1 || RSP_ERR !== 1'b1 || RSP_OUT !== 32'h0 || RSP_ZERO !== 1'b1) begin
      errors++; $display("FAIL illegal_rsp: vld=%b e=%b out=%h z=%b expected 1/1/0/1", RSP0_VALID, RSP_ERR, RSP_OUT, RSP_ZERO);
    end
    tick();
    // Upper opcode bits reach the ALU but do not affect the legality decode.
    REQ0_VALID = 1; REQ0_OP1 = 32'd1; REQ0_OP2 = 32'd2; REQ0_OPRN = 6'h31;
    tick();
    REQ0_VALID = 0;
    checks++;
    if (ALU_OPRN !== 6'h31) begin
      errors++; $display("FAIL oprn_fwd: got %h expected 31", ALU_OPRN);
    end
    tick();
    checks++;
    if (RSP0_VALID !== 1'b1 || RSP_ERR !== 1'b0) begin
      errors++; $display("FAIL oprn_upper_err: vld=%b e=%b expected 1/0", RSP0_VALID, RSP_ERR);
    end
    tick();
    idle_inputs();
    #1;
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    REQ1_VALID = 1; REQ1_OP1 = 32'd4; REQ1_OP2 = 32'd4; REQ1_OPRN = OPRN_ADD;
    tick();
    RST = 1;
    #1;
    checks++;
    if ({REQ1_READY, REQ0_READY} !== 2'b00) begin
      errors++; $display("FAIL rst_exec_ready: got %b expected 00", {REQ1_READY, REQ0_READY});
    end
    REQ1_VALID = 0;
    tick();
    RST = 0;
    #1;
    checks++;
    if ({RSP0_VALID, RSP1_VALID, RSP_ZERO, RSP_ERR} !== 4'b0000 || RSP_OUT !== 32'h0 ||
        ALU_OP1 !== 32'h0 || ALU_OPRN !== 6'h0) begin
      errors++; $display("FAIL rst_exec_state: flags=%b out=%h op1=%h oprn=%h expected all 0", {RSP0_VALID, RSP1_VALID, RSP_ZERO, RSP_ERR}, RSP_OUT, ALU_OP1, ALU_OPRN);
    end
    tick();
    checks++;
    if (RSP1_VALID !== 1'b0) begin
      errors++; $display("FAIL rst_exec_noresp: vld1=%b expected 0", RSP1_VALID);
    end
    // REQ0 op held in RESP, then reset; LAST must return to 1.
    REQ0_VALID = 1; REQ0_OP1 = 32'd9; REQ0_OP2 = 32'd1; REQ0_OPRN = OPRN_SUB; RSP0_READY = 0;
    tick();
    REQ0_VALID = 0;
    tick();
    checks++;
    if (RSP0_VALID !== 1'b1 || RSP_OUT !== 32'd8) begin
      errors++; $display("FAIL rst_resp_pre: vld0=%b out=%h expected 1/8", RSP0_VALID, RSP_OUT);
    end
    RST = 1;
    tick();
    RST = 0;
    #1;
    checks++;
    if ({RSP0_VALID, RSP1_VALID} !== 2'b00 || RSP_OUT !== 32'h0 || ALU_OP1 !== 32'h0) begin
      errors++; $display("FAIL rst_resp_state: vld=%b out=%h op1=%h expected 00/0/0", {RSP0_VALID, RSP1_VALID}, RSP_OUT, ALU_OP1);
    end
    REQ0_VALID = 1; REQ1_VALID = 1;
    #1;
    checks++;
    if ({REQ1_READY, REQ0_READY} !== 2'b01) begin
      errors++; $display("FAIL rst_tie: ready1,0=%b expected 01", {REQ1_READY, REQ0_READY});
    end
    idle_inputs();
    #1;
  endtask

  task automatic test_payload_stability();
    REQ0_VALID = 1; REQ0_OP1 = 32'h00010000; REQ0_OP2 = 32'h00010000; REQ0_OPRN = OPRN_MUL;
    RSP0_READY = 1;
    tick();
    REQ0_VALID = 0; REQ0_OP1 = 32'd3; REQ0_OP2 = 32'd3; REQ0_OPRN = OPRN_ADD;
    #1;
    checks++;
    if (ALU_OP1 !== 32'h00010000 || ALU_OPRN !== OPRN_MUL) begin
      errors++; $display("FAIL payload_latched: op1=%h oprn=%h expected 00010000/03", ALU_OP1, ALU_OPRN);
    end
    tick();
    checks++;
    if (RSP0_VALID !== 1'b1 || RSP_OUT !== 32'h0 || RSP_ZERO !== 1'b1 || RSP_ERR !== 1'b0) begin
      errors++; $display("FAIL payload_rsp: vld=%b out=%h z=%b e=%b expected 1/0/1/0", RSP0_VALID, RSP_OUT, RSP_ZERO, RSP_ERR);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_reset_mid_op();
    test_payload_stability();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
